// File: rtl/sxp_int_pkg.sv
// Shared definitions for the SXP interrupt controller and the fetch stage.
package sxp_int_pkg;

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_REQ = 2'b01,
        ST_SVC = 2'b10
    } int_state_t;

    localparam logic [31:0] IDLE_NOP   = 32'h5800_0000;
    localparam logic [15:0] JAL_PREFIX = 16'h581F;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending lines.
module int_prio_enc #(
    parameter int NUM_INT = 16
) (
    input  logic [NUM_INT-1:0] req,
    output logic [3:0]         idx,
    output logic               any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// SXP interrupt controller: edge capture, masking, priority pick, JAL
// request sequencing to fetch, and ownership of the core idle signal.
module int_ctrl
    import sxp_int_pkg::*;
#(
    parameter int          NUM_INT  = 16,
    parameter logic [15:0] VEC_BASE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [NUM_INT-1:0] int_req,
    input  logic               int_en,
    input  logic               int_mask_we,
    input  logic               int_clr_we,
    input  logic [NUM_INT-1:0] int_wdata,
    input  logic               jal_taken,
    input  logic               int_ret,
    input  logic               sleep_req,
    output logic               jal_req,
    output logic [15:0]        int_srv_num,
    output logic               idle,
    output logic [NUM_INT-1:0] int_mask,
    output logic [NUM_INT-1:0] int_pending,
    output logic               int_active,
    output logic [3:0]         int_active_num
);

    int_state_t         state, state_nxt;
    logic [NUM_INT-1:0] int_req_d;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] clr;
    logic [NUM_INT-1:0] enabled;
    logic [3:0]         sel;
    logic               any;
    logic               start;

    assign rise    = int_req & ~int_req_d;
    assign enabled = int_pending & int_mask;
    assign start   = (state == ST_RUN) && (state_nxt == ST_REQ);

    int_prio_enc #(.NUM_INT(NUM_INT)) u_prio (
        .req (enabled),
        .idx (sel),
        .any (any)
    );

    // Software clear plus auto-clear of the line whose JAL fetch just took.
    always_comb begin
        clr = '0;
        if (int_clr_we)
            clr = int_wdata;
        if ((state == ST_REQ) && jal_taken)
            clr = clr | (NUM_INT'(1) << int_active_num);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            int_req_d   <= '0;
            int_pending <= '0;
            int_mask    <= '0;
        end else begin
            int_req_d   <= int_req;
            int_pending <= (int_pending & ~clr) | rise;
            if (int_mask_we)
                int_mask <= int_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // jal_taken outranks a dropped int_en while requesting.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: if (int_en && any) state_nxt = ST_REQ;
            ST_REQ: begin
                if (jal_taken)
                    state_nxt = ST_SVC;
                else if (!int_en)
                    state_nxt = ST_RUN;
            end
            ST_SVC: if (int_ret) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        jal_req    = (state == ST_REQ);
        int_active = (state == ST_SVC);
    end

    // Line and vector are frozen for the whole REQ/SVC span.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            int_active_num <= '0;
            int_srv_num    <= '0;
        end else if (start) begin
            int_active_num <= sel;
            int_srv_num    <= VEC_BASE + 16'(sel);
        end
    end

    // Wake outranks a sleep request in the same cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            idle <= 1'b0;
        else if (any)
            idle <= 1'b0;
        else if (sleep_req)
            idle <= 1'b1;
    end

endmodule
